// File: rtl/msx_slot_bus_bridge_pkg.sv
// Shared definitions for the MSX slot bus bridge: FSM state encodings,
// timeout counter width and the open-bus value returned on unclaimed reads.
// Pure definitions, no logic; no latency or backpressure.
package msx_slot_bus_bridge_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_REQ  = 3'd1,
    RD_WAIT = 3'd2,
    RD_HOLD = 3'd3,
    WR_REQ  = 3'd4,
    WR_HOLD = 3'd5
  } state_t;

  localparam int         TMO_W    = 4;
  localparam logic [7:0] OPEN_BUS = 8'hFF;

endpackage

// File: rtl/msx_sync_2ff.sv
// Two-flop synchronizer for asynchronous slot strobes, with a tap on the first stage.
// Latency: 2 clk to q, 1 clk to q_first.
// No backpressure; samples every cycle.
module msx_sync_2ff #(
  parameter int             W       = 1,
  parameter logic [W-1:0]   RST_VAL = '1
) (
  input  logic         clk,
  input  logic         n_reset,
  input  logic [W-1:0] d,
  output logic [W-1:0] q,
  output logic [W-1:0] q_first
);

  logic [W-1:0] stage1, stage2;

  // Shift the raw inputs through two flops; strobes reset to their idle (high) level.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      stage1 <= RST_VAL;
      stage2 <= RST_VAL;
    end else begin
      stage1 <= d;
      stage2 <= stage1;
    end
  end

  assign q       = stage2;
  assign q_first = stage1;

endmodule

// File: rtl/msx_slot_bus_bridge.sv
// Cartridge-slot to internal bus initiator: strobes -> one-cycle bus_read/bus_write pulses, read data back with WAIT.
// Latency: slot strobe edge to bus pulse is 3 clk (2 sync + 1 latch); all outputs registered.
// Backpressure: reads hold slot_n_wait low until bus_read_ready or timeout; writes are fire-and-forget.
module msx_slot_bus_bridge
  import msx_slot_bus_bridge_pkg::*;
#(
  parameter bit               WAIT_EN = 1'b1,
  parameter bit               IO_EN   = 1'b1,
  parameter logic [TMO_W-1:0] TIMEOUT = 4'd15
) (
  input  logic        clk,
  input  logic        n_reset,
  input  logic [15:0] slot_a,
  input  logic [7:0]  slot_d_in,
  output logic [7:0]  slot_d_out,
  output logic        slot_d_oe,
  input  logic        slot_n_sltsl,
  input  logic        slot_n_merq,
  input  logic        slot_n_iorq,
  input  logic        slot_n_rd,
  input  logic        slot_n_wr,
  output logic        slot_n_wait,
  output logic [15:0] bus_address,
  output logic [7:0]  bus_write_data,
  output logic        bus_read,
  output logic        bus_write,
  output logic        bus_memory,
  input  logic        bus_read_ready,
  input  logic [7:0]  bus_read_data
);

  logic [4:0] strb_raw, strb_q, strb_first;
  logic [3:0] sync_first_unused;
  logic       mem_hit, io_hit, hit, rd_now, wr_now, rd_next;
  logic       cap, fill;
  state_t     state, next_state;
  logic [TMO_W-1:0] tmo_cnt;

  assign strb_raw = {slot_n_sltsl, slot_n_merq, slot_n_iorq, slot_n_rd, slot_n_wr};

  msx_sync_2ff #(.W(5), .RST_VAL(5'b11111)) u_sync (
    .clk     (clk),
    .n_reset (n_reset),
    .d       (strb_raw),
    .q       (strb_q),
    .q_first (strb_first)
  );

  // Only the read strobe needs a look-ahead: it lets oe drop on the same edge the synchronized n_rd rises.
  assign sync_first_unused = {strb_first[4:2], strb_first[0]};

  assign mem_hit = !strb_q[4] && !strb_q[3];
  assign io_hit  = IO_EN && !strb_q[2];
  assign hit     = mem_hit || io_hit;
  assign rd_now  = !strb_q[1];
  assign wr_now  = !strb_q[0];
  assign rd_next = !strb_first[1];

  // State register.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) state <= IDLE;
    else          state <= next_state;
  end

  // Next-state decode; cap/fill mark the cycle that loads read data for the slot.
  always_comb begin
    next_state = state;
    cap        = 1'b0;
    fill       = 1'b0;
    case (state)
      IDLE: begin
        if (hit && rd_now && !wr_now)      next_state = RD_REQ;
        else if (hit && wr_now && !rd_now) next_state = WR_REQ;
      end
      RD_REQ: begin
        if (!rd_now) begin
          next_state = IDLE;
        end else if (bus_read_ready) begin
          cap        = 1'b1;
          next_state = RD_HOLD;
        end else begin
          next_state = RD_WAIT;
        end
      end
      RD_WAIT: begin
        if (!rd_now) begin
          next_state = IDLE;
        end else if (bus_read_ready) begin
          cap        = 1'b1;
          next_state = RD_HOLD;
        end else if (tmo_cnt == TIMEOUT) begin
          // Unclaimed memory reads return open bus; unclaimed I/O is left to other devices.
          fill       = bus_memory;
          next_state = RD_HOLD;
        end
      end
      RD_HOLD: if (!rd_now) next_state = IDLE;
      WR_REQ:  next_state = WR_HOLD;
      WR_HOLD: if (!wr_now) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Registered outputs, address/data latches and the read timeout counter.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      bus_address    <= '0;
      bus_write_data <= '0;
      bus_read       <= 1'b0;
      bus_write      <= 1'b0;
      bus_memory     <= 1'b0;
      slot_d_out     <= '0;
      slot_d_oe      <= 1'b0;
      slot_n_wait    <= 1'b1;
      tmo_cnt        <= '0;
    end else begin
      bus_read    <= (next_state == RD_REQ);
      bus_write   <= (next_state == WR_REQ);
      slot_n_wait <= !(WAIT_EN && (next_state == RD_REQ || next_state == RD_WAIT));
      tmo_cnt     <= (state == RD_WAIT) ? tmo_cnt + 1'b1 : '0;
      if (state == IDLE && (next_state == RD_REQ || next_state == WR_REQ)) begin
        bus_address <= slot_a;
        bus_memory  <= mem_hit;
      end
      if (state == IDLE && next_state == WR_REQ) bus_write_data <= slot_d_in;
      if (cap)       slot_d_out <= bus_read_data;
      else if (fill) slot_d_out <= OPEN_BUS;
      slot_d_oe <= rd_next &&
                   (cap || fill || (state == RD_HOLD && next_state == RD_HOLD && slot_d_oe));
    end
  end

endmodule

// File: tb/tb_msx_slot_bus_bridge.sv
// Scoreboard bench for msx_slot_bus_bridge: expected bus transactions queued at stimulus, popped on pulses.
// A second instance with IO_EN=0 shares the stimulus to show I/O cycles are ignored there.
// Responder model answers bus_read after a programmable delay, or not at all.
module tb_msx_slot_bus_bridge;

  typedef struct packed {
    logic        wr;
    logic        mem;
    logic [15:0] a;
    logic [7:0]  d;
  } exp_t;

  logic        clk = 1'b0;
  logic        n_reset;
  logic [15:0] slot_a;
  logic [7:0]  slot_d_in;
  logic        n_sltsl, n_merq, n_iorq, n_rd, n_wr;
  logic        ready;
  logic [7:0]  rdata;

  logic [7:0]  d_out, x_d_out;
  logic        d_oe, x_d_oe, n_wait, x_n_wait;
  logic [15:0] b_addr, x_b_addr;
  logic [7:0]  b_wdata, x_b_wdata;
  logic        b_read, x_b_read, b_write, x_b_write, b_mem, x_b_mem;

  exp_t sbq[$];
  int   n_cmp = 0, n_bad = 0;
  int   rd_cnt = 0, wr_cnt = 0, x_rd_cnt = 0;
  bit   resp_en;
  int   resp_delay;
  logic [7:0] resp_data;

  always #5 clk = ~clk;

  msx_slot_bus_bridge #(.WAIT_EN(1'b1), .IO_EN(1'b1), .TIMEOUT(4'd15)) dut (
    .clk(clk), .n_reset(n_reset), .slot_a(slot_a), .slot_d_in(slot_d_in),
    .slot_d_out(d_out), .slot_d_oe(d_oe), .slot_n_sltsl(n_sltsl), .slot_n_merq(n_merq),
    .slot_n_iorq(n_iorq), .slot_n_rd(n_rd), .slot_n_wr(n_wr), .slot_n_wait(n_wait),
    .bus_address(b_addr), .bus_write_data(b_wdata), .bus_read(b_read), .bus_write(b_write),
    .bus_memory(b_mem), .bus_read_ready(ready), .bus_read_data(rdata)
  );

  msx_slot_bus_bridge #(.WAIT_EN(1'b1), .IO_EN(1'b0), .TIMEOUT(4'd15)) dut_noio (
    .clk(clk), .n_reset(n_reset), .slot_a(slot_a), .slot_d_in(slot_d_in),
    .slot_d_out(x_d_out), .slot_d_oe(x_d_oe), .slot_n_sltsl(n_sltsl), .slot_n_merq(n_merq),
    .slot_n_iorq(n_iorq), .slot_n_rd(n_rd), .slot_n_wr(n_wr), .slot_n_wait(x_n_wait),
    .bus_address(x_b_addr), .bus_write_data(x_b_wdata), .bus_read(x_b_read), .bus_write(x_b_write),
    .bus_memory(x_b_mem), .bus_read_ready(ready), .bus_read_data(rdata)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic push_exp(input logic wr, input logic mem, input logic [15:0] a, input logic [7:0] d);
    exp_t e;
    e.wr = wr; e.mem = mem; e.a = a; e.d = d;
    sbq.push_back(e);
  endtask

  task automatic idle_bus();
    n_sltsl = 1'b1; n_merq = 1'b1; n_iorq = 1'b1; n_rd = 1'b1; n_wr = 1'b1;
  endtask

  // Count pulses and pop the scoreboard on each one.
  always @(negedge clk) begin
    exp_t e;
    if (b_read || b_write) begin
      if (b_read)  rd_cnt++;
      if (b_write) wr_cnt++;
      chk("rd_wr_excl", {31'd0, b_read && b_write}, 32'd0);
      if (sbq.size() == 0) begin
        chk("sb_unexpected_pulse", 32'd1, 32'd0);
      end else begin
        e = sbq.pop_front();
        chk("sb_kind", {31'd0, b_write}, {31'd0, e.wr});
        chk("sb_memory", {31'd0, b_mem}, {31'd0, e.mem});
        chk("sb_addr", {16'd0, b_addr}, {16'd0, e.a});
        if (e.wr) chk("sb_wdata", {24'd0, b_wdata}, {24'd0, e.d});
      end
    end
    if (x_b_read) x_rd_cnt++;
  end

  // Responder: answers each bus_read after resp_delay cycles with resp_data.
  initial begin
    ready = 1'b0;
    rdata = 8'h00;
    forever begin
      @(negedge clk);
      if (b_read && resp_en) begin
        repeat (resp_delay) @(negedge clk);
        rdata = resp_data;
        ready = 1'b1;
        @(negedge clk);
        ready = 1'b0;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int lat, c0, c1;
    bit oe_seen;
    n_reset = 1'b0;
    idle_bus();
    slot_a = 16'h0000; slot_d_in = 8'h00;
    resp_en = 1'b1; resp_delay = 0; resp_data = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_wait", {31'd0, n_wait}, 32'd1);
    chk("rst_oe", {31'd0, d_oe}, 32'd0);
    chk("rst_addr", {16'd0, b_addr}, 32'd0);
    chk("rst_pulses", {30'd0, b_read, b_write}, 32'd0);
    n_reset = 1'b1;
    repeat (3) @(negedge clk);

    // Memory read, responder ready 2 clk after the pulse.
    resp_en = 1'b1; resp_delay = 2; resp_data = 8'hA5;
    push_exp(1'b0, 1'b1, 16'h9800, 8'h00);
    slot_a = 16'h9800; n_sltsl = 1'b0; n_merq = 1'b0; n_rd = 1'b0;
    lat = 0;
    while (!b_read && lat < 20) begin @(negedge clk); lat++; end
    chk("rd_latency", lat, 32'd3);
    chk("rd_wait_low", {31'd0, n_wait}, 32'd0);
    for (int i = 0; i < 30 && !d_oe; i++) @(negedge clk);
    chk("rd_oe", {31'd0, d_oe}, 32'd1);
    chk("rd_data", {24'd0, d_out}, 32'h0000_00A5);
    chk("rd_wait_rel", {31'd0, n_wait}, 32'd1);
    repeat (4) @(negedge clk);
    chk("rd_oe_hold", {31'd0, d_oe}, 32'd1);
    n_rd = 1'b1;
    repeat (4) @(negedge clk);
    chk("rd_oe_off", {31'd0, d_oe}, 32'd0);
    idle_bus();
    repeat (3) @(negedge clk);

    // Memory write, strobe held 20 clk.
    c0 = wr_cnt;
    push_exp(1'b1, 1'b1, 16'h9880, 8'h3C);
    slot_a = 16'h9880; slot_d_in = 8'h3C; n_sltsl = 1'b0; n_merq = 1'b0; n_wr = 1'b0;
    lat = 0;
    while (!b_write && lat < 20) begin @(negedge clk); lat++; end
    chk("wr_latency", lat, 32'd3);
    repeat (17) @(negedge clk);
    n_wr = 1'b1;
    repeat (5) @(negedge clk);
    chk("wr_once", wr_cnt - c0, 32'd1);
    idle_bus();
    repeat (3) @(negedge clk);

    // I/O read with no responder: wait released after timeout, never drives the bus.
    resp_en = 1'b0;
    c1 = x_rd_cnt;
    push_exp(1'b0, 1'b0, 16'h00A0, 8'h00);
    slot_a = 16'h00A0; n_iorq = 1'b0; n_rd = 1'b0;
    lat = 0;
    while (!b_read && lat < 20) begin @(negedge clk); lat++; end
    chk("io_latency", lat, 32'd3);
    oe_seen = 1'b0; lat = 0;
    while (!n_wait && lat < 40) begin @(negedge clk); lat++; oe_seen |= d_oe; end
    chk("io_tmo_len", lat, 32'd17);
    repeat (3) begin @(negedge clk); oe_seen |= d_oe; end
    chk("io_no_oe", {31'd0, oe_seen}, 32'd0);
    n_rd = 1'b1;
    repeat (4) @(negedge clk);
    chk("noio_no_read", x_rd_cnt - c1, 32'd0);
    chk("noio_wait_high", {31'd0, x_n_wait}, 32'd1);
    idle_bus();
    repeat (3) @(negedge clk);

    // Memory read with no responder: open-bus 8'hFF after timeout.
    push_exp(1'b0, 1'b1, 16'h9000, 8'h00);
    slot_a = 16'h9000; n_sltsl = 1'b0; n_merq = 1'b0; n_rd = 1'b0;
    for (int i = 0; i < 20 && !b_read; i++) @(negedge clk);
    lat = 0;
    while (!d_oe && lat < 40) begin @(negedge clk); lat++; end
    chk("mem_tmo_len", lat, 32'd17);
    chk("mem_tmo_data", {24'd0, d_out}, 32'h0000_00FF);
    chk("mem_tmo_wait", {31'd0, n_wait}, 32'd1);
    n_rd = 1'b1;
    repeat (4) @(negedge clk);
    chk("mem_tmo_oe_off", {31'd0, d_oe}, 32'd0);
    idle_bus();
    repeat (3) @(negedge clk);

    // Abort: n_rd released while waiting, ready arrives late and must be discarded.
    resp_en = 1'b1; resp_delay = 12; resp_data = 8'h11;
    push_exp(1'b0, 1'b1, 16'h9801, 8'h00);
    slot_a = 16'h9801; n_sltsl = 1'b0; n_merq = 1'b0; n_rd = 1'b0;
    for (int i = 0; i < 20 && !b_read; i++) @(negedge clk);
    repeat (2) @(negedge clk);
    n_rd = 1'b1;
    oe_seen = 1'b0;
    repeat (20) begin @(negedge clk); oe_seen |= d_oe; end
    chk("abort_no_oe", {31'd0, oe_seen}, 32'd0);
    chk("abort_wait", {31'd0, n_wait}, 32'd1);
    idle_bus();
    repeat (3) @(negedge clk);

    // Next access after the abort, with zero-latency ready.
    resp_delay = 0; resp_data = 8'h5A;
    push_exp(1'b0, 1'b1, 16'h9802, 8'h00);
    slot_a = 16'h9802; n_sltsl = 1'b0; n_merq = 1'b0; n_rd = 1'b0;
    for (int i = 0; i < 30 && !d_oe; i++) @(negedge clk);
    chk("post_abort_oe", {31'd0, d_oe}, 32'd1);
    chk("post_abort_data", {24'd0, d_out}, 32'h0000_005A);
    n_rd = 1'b1;
    repeat (4) @(negedge clk);
    idle_bus();
    repeat (3) @(negedge clk);

    // Reset pulsed during RD_HOLD.
    resp_delay = 1; resp_data = 8'h77;
    push_exp(1'b0, 1'b1, 16'h9803, 8'h00);
    slot_a = 16'h9803; n_sltsl = 1'b0; n_merq = 1'b0; n_rd = 1'b0;
    for (int i = 0; i < 30 && !d_oe; i++) @(negedge clk);
    chk("hold_data", {24'd0, d_out}, 32'h0000_0077);
    @(negedge clk);
    #2 n_reset = 1'b0;
    #1;
    chk("arst_oe", {31'd0, d_oe}, 32'd0);
    chk("arst_wait", {31'd0, n_wait}, 32'd1);
    chk("arst_addr", {16'd0, b_addr}, 32'd0);
    chk("arst_dout", {24'd0, d_out}, 32'd0);
    idle_bus();
    repeat (3) @(negedge clk);
    n_reset = 1'b1;
    repeat (3) @(negedge clk);

    // n_rd and n_wr both low: no pulse.
    c0 = rd_cnt + wr_cnt;
    slot_a = 16'h9804; n_sltsl = 1'b0; n_merq = 1'b0; n_rd = 1'b0; n_wr = 1'b0;
    repeat (10) @(negedge clk);
    chk("rdwr_both_ignored", rd_cnt + wr_cnt - c0, 32'd0);
    idle_bus();
    repeat (5) @(negedge clk);

    chk("sb_drained", sbq.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
